// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and default constants for the memory arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY_I, BUSY_D, DONE)
//   port_t  : requester identity (PORT_I = fetch, PORT_D = load/store)
//   DEF_*   : default address/data widths and busy timeout
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick -- combinational requester picker.
//   i_req   : fetch port requesting
//   d_req   : load/store port requesting
//   i_last  : port granted most recently
//   o_port  : selected port
//   o_valid : at least one request present
// Build option: MEM_ARB_RR_EN selects round-robin on contention;
// otherwise the load/store port has fixed priority and i_last is unused.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  i_req,
  input  logic  d_req,
  input  port_t i_last,
  output port_t o_port,
  output logic  o_valid
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    o_valid = i_req | d_req;
    o_port  = PORT_I;
    if (i_req && d_req) begin
      // contention: favour whichever port did not win last time
      o_port = (i_last == PORT_D) ? PORT_I : PORT_D;
    end else if (d_req) begin
      o_port = PORT_D;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last;

  always_comb begin
    o_valid = i_req | d_req;
    o_port  = d_req ? PORT_D : PORT_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port (fetch / load-store) arbiter onto one memory port.
//   clk, reset                         : clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata          : fetch port (read only)
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata : load/store port
//   err                                : completion was a timeout abort
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready : memory side
// Build option: MEM_ARB_RR_EN enables round-robin arbitration with a
// last-grant register; default build uses fixed D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // counter only needs to reach TIMEOUT_CYC-1
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  port_t             r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  port_t             w_pick_port;
  logic              w_pick_valid;
  port_t             w_last;
  logic              w_grant;
  logic              w_busy;
  logic              w_tmo;
  logic [DATA_W-1:0] w_rd;

`ifdef MEM_ARB_RR_EN
  port_t r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= PORT_I;
    end else if (w_grant) begin
      r_last <= w_pick_port;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = PORT_I;
`endif

  mem_arb_pick u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
    .i_last  (w_last),
    .o_port  (w_pick_port),
    .o_valid (w_pick_valid)
  );

  assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_tmo  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  // completion data: writes and timeouts return zero
  assign w_rd   = (mem_ready && !r_we) ? mem_rdata : '0;

  assign mem_we    = w_busy & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

  // handshake outputs are masked while reset is held so an aborted
  // access never produces a grant, rvalid or err
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    mem_req     = 1'b0;
    i_rvalid    = 1'b0;
    d_rvalid    = 1'b0;
    err         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid && !reset) begin
          w_grant = 1'b1;
          if (w_pick_port == PORT_D) begin
            d_gnt       = 1'b1;
            w_state_nxt = BUSY_D;
          end else begin
            i_gnt       = 1'b1;
            w_state_nxt = BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        mem_req = 1'b1;
        if (mem_ready || w_tmo) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (!reset) begin
          i_rvalid = (r_port == PORT_I);
          d_rvalid = (r_port == PORT_D);
          err      = r_err;
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_port    <= PORT_I;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_port <= w_pick_port;
        r_cnt  <= '0;
        r_err  <= 1'b0;
        if (w_pick_port == PORT_D) begin
          r_we    <= d_we;
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
        end else begin
          r_we    <= 1'b0;
          r_addr  <= i_addr;
          r_wdata <= '0;
        end
      end else if (w_busy) begin
        if (mem_ready || w_tmo) begin
          // mem_ready wins over a coincident expiry
          r_err <= ~mem_ready;
          if (r_state == BUSY_I) begin
            r_i_rdata <= w_rd;
          end else begin
            r_d_rdata <= w_rd;
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter
// (TIMEOUT_CYC = 4). Contention expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int unsigned n_vec;
  int unsigned n_err;

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // inputs change 1ns after the rising edge; outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic exp_d;
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    // ---- reset state, requests present while reset held
    tick(); tick();
    i_req = 1'b1; d_req = 1'b1;
    settle();
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rvalid", 32'({i_rvalid, d_rvalid, err}), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    i_req = 1'b0; d_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // ---- lone fetch, mem_ready 2 cycles after mem_req rises
    i_req = 1'b1; i_addr = 32'h40;
    settle();
    chk("f_i_gnt", 32'(i_gnt), 32'd1);
    chk("f_d_gnt", 32'(d_gnt), 32'd0);
    chk("f_memreq_idle", 32'(mem_req), 32'd0);
    tick();
    i_req = 1'b0; i_addr = 32'hFFFF_FFFF;
    settle();
    chk("f_busy1_req", 32'(mem_req), 32'd1);
    chk("f_busy1_addr", mem_addr, 32'h40);
    chk("f_busy1_we", 32'(mem_we), 32'd0);
    chk("f_busy1_gnt", 32'(i_gnt), 32'd0);
    tick();
    settle();
    chk("f_busy2_addr", mem_addr, 32'h40);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("f_busy3_rvalid", 32'(i_rvalid), 32'd0);
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    settle();
    chk("f_done_rvalid", 32'(i_rvalid), 32'd1);
    chk("f_done_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("f_done_err", 32'(err), 32'd0);
    chk("f_done_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("f_done_memreq", 32'(mem_req), 32'd0);
    tick();
    settle();
    chk("f_idle_rvalid", 32'(i_rvalid), 32'd0);
    chk("f_idle_hold", i_rdata, 32'hDEAD_BEEF);

    // ---- store, mem_ready on first busy cycle (read data must be ignored)
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
    settle();
    chk("s_d_gnt", 32'(d_gnt), 32'd1);
    chk("s_i_gnt", 32'(i_gnt), 32'd0);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    settle();
    chk("s_memreq", 32'(mem_req), 32'd1);
    chk("s_memwe", 32'(mem_we), 32'd1);
    chk("s_memaddr", mem_addr, 32'h100);
    chk("s_memwdata", mem_wdata, 32'h1234_5678);
    tick();
    mem_ready = 1'b0;
    settle();
    chk("s_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("s_d_rdata", d_rdata, 32'd0);
    chk("s_err", 32'(err), 32'd0);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("s_idle_rvalid", 32'(d_rvalid), 32'd0);
    chk("s_idle_ready_ignored", 32'(mem_req), 32'd0);
    tick();
    mem_ready = 1'b0;
    settle();
    chk("s_idle_stays", 32'({mem_req, d_rvalid, i_rvalid}), 32'd0);

    // ---- contention from a fresh reset, mem_ready held high throughout
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h200; d_addr = 32'h300;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      mem_rdata = 32'h1000 + 32'(k);
      settle();
      chk($sformatf("c%0d_d_gnt", k), 32'(d_gnt), 32'(exp_d));
      chk($sformatf("c%0d_i_gnt", k), 32'(i_gnt), 32'(!exp_d));
      tick();
      settle();
      chk($sformatf("c%0d_addr", k), mem_addr, exp_d ? 32'h300 : 32'h200);
      tick();
      settle();
      chk($sformatf("c%0d_d_rvalid", k), 32'(d_rvalid), 32'(exp_d));
      chk($sformatf("c%0d_i_rvalid", k), 32'(i_rvalid), 32'(!exp_d));
      chk($sformatf("c%0d_rdata", k), exp_d ? d_rdata : i_rdata, 32'h1000 + 32'(k));
      chk($sformatf("c%0d_gnt_in_done", k), 32'({i_gnt, d_gnt}), 32'd0);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;

    // ---- timeout: load never answered
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h55;
    settle();
    chk("t_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      settle();
      chk($sformatf("t_busy%0d", b), 32'({mem_req, d_rvalid, err}), 32'b100);
      tick();
    end
    settle();
    chk("t_done_rvalid", 32'(d_rvalid), 32'd1);
    chk("t_done_err", 32'(err), 32'd1);
    chk("t_done_rdata", d_rdata, 32'd0);
    tick();
    settle();
    chk("t_idle", 32'({mem_req, d_rvalid, err}), 32'd0);

    // ---- mem_ready on the expiry cycle completes normally
    i_req = 1'b1; i_addr = 32'h80;
    settle();
    chk("p_i_gnt", 32'(i_gnt), 32'd1);
    tick();
    i_req = 1'b0;
    for (int b = 0; b < 3; b++) begin
      settle();
      chk($sformatf("p_busy%0d", b), 32'(mem_req), 32'd1);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    settle();
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    settle();
    chk("p_done_rvalid", 32'(i_rvalid), 32'd1);
    chk("p_done_err", 32'(err), 32'd0);
    chk("p_done_rdata", i_rdata, 32'hCAFE_F00D);
    tick();
    settle();

    // ---- reset in the second busy cycle, then a fresh store
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h77;
    settle();
    chk("r_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0;
    settle();
    tick();
    reset = 1'b1;
    settle();
    chk("r_busy2_rvalid", 32'({d_rvalid, err}), 32'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("r_after_memreq", 32'(mem_req), 32'd0);
    chk("r_after_rvalid", 32'({d_rvalid, i_rvalid, err}), 32'd0);
    chk("r_after_i_rdata", i_rdata, 32'd0);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h88; d_wdata = 32'h99;
    settle();
    chk("r_fresh_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    mem_ready = 1'b1;
    settle();
    chk("r_fresh_addr", mem_addr, 32'h88);
    chk("r_fresh_we", 32'(mem_we), 32'd1);
    tick();
    mem_ready = 1'b0;
    settle();
    chk("r_fresh_rvalid", 32'(d_rvalid), 32'd1);
    chk("r_fresh_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
